// File: rtl/unshifter_pkg.sv
// Shared types and constants for the unshifter block.
// Optional feature macro used by unshifter: UNSHIFTER_ZERO_BYPASS_EN.
package unshifter_pkg;

  // Default data width, shared with the shifter benches.
  localparam int unsigned UNSHIFTER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } unshifter_state_t;

endpackage

// File: rtl/unshifter_rotl1.sv
// Combinational one-position left rotate on the unshifter data feedback path.
module unshifter_rotl1
  import unshifter_pkg::*;
#(
  parameter int unsigned WIDTH = UNSHIFTER_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  assign y = {d[WIDTH-2:0], d[WIDTH-1]};

endmodule

// File: rtl/unshifter.sv
// Sequential left-rotator undoing the shifter block's right rotation, one bit per cycle.
// Build option: define UNSHIFTER_ZERO_BYPASS_EN to send shift=0 words straight to DONE.
module unshifter
  import unshifter_pkg::*;
#(
  parameter int unsigned WIDTH = UNSHIFTER_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("unshifter: WIDTH must be a power of two and at least 2");
  end

  unshifter_state_t state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_rotl;
  logic [SHW-1:0]   cnt;

  unshifter_rotl1 #(.WIDTH(WIDTH)) u_rotl1 (
    .d (data),
    .y (data_rotl)
  );

  // Control, data path and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      cnt       <= '0;
      q         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data     <= in;
            cnt      <= shift;
            in_ready <= 1'b0;
`ifdef UNSHIFTER_ZERO_BYPASS_EN
            if (shift == '0) begin
              q         <= in;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ROT;
            end
`else
            state    <= ROT;
`endif
          end
        end
        ROT: begin
          if (cnt != '0) begin
            data <= data_rotl;
            cnt  <= cnt - SHW'(1);
          end else begin
            q         <= data;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unshifter.sv
// Directed self-checking bench for unshifter; shifter output is modelled by rotr().
module tb_unshifter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SHW   = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shift;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;

  int n_checks;
  int n_pass;

  unshifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int k);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> k;
    return dbl[WIDTH-1:0];
  endfunction

  function automatic int exp_lat(input int k);
`ifdef UNSHIFTER_ZERO_BYPASS_EN
    if (k == 0) return 1;
`endif
    return k + 2;
  endfunction

  // Accept one word, wait (bounded) for out_valid, check latency and q.
  task automatic run_word(input string tag, input logic [WIDTH-1:0] w,
                          input int k, input logic [WIDTH-1:0] exp_q);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in       = w;
    shift    = SHW'(k);
    tick();
    in_valid = 1'b0;
    in       = ~w;
    shift    = ~SHW'(k);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(k)));
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in        = '0;
    shift     = '0;
    out_ready = 1'b1;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // shift=1: out_valid only in cycle n+3, in_ready back in n+4.
    in_valid = 1'b1; in = 4'b1000; shift = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("s1_ov_n1", 32'(out_valid), 32'd0);
    chk("s1_ir_n1", 32'(in_ready), 32'd0);
    tick();
    chk("s1_ov_n2", 32'(out_valid), 32'd0);
    tick();
    chk("s1_ov_n3", 32'(out_valid), 32'd1);
    chk("s1_q_n3", 32'(q), 32'b0001);
    tick();
    chk("s1_ov_n4", 32'(out_valid), 32'd0);
    chk("s1_ir_n4", 32'(in_ready), 32'd1);
    chk("s1_q_hold", 32'(q), 32'b0001);

    run_word("s3", 4'b0001, 3, 4'b1000);
    tick();
    run_word("s0", 4'b1010, 0, 4'b1010);
    tick();

    // Backpressure with a competing word on the input.
    out_ready = 1'b0;
    run_word("s2", 4'b0110, 2, 4'b1001);
    in_valid = 1'b1; in = 4'b1111; shift = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_q_%0d", i), 32'(q), 32'b1001);
      chk($sformatf("bp_ov_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ir_%0d", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ir", 32'(in_ready), 32'd1);
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    chk("bp_release_q", 32'(q), 32'b1001);

    // Reset in the middle of ROT aborts the word.
    in_valid = 1'b1; in = 4'b0100; shift = 2'd3;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_q", 32'(q), 32'h0);
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_ir", 32'(in_ready), 32'd1);
    tick();
    chk("abort_idle_ov", 32'(out_valid), 32'd0);

    // Round trip through the shifter model for every value and amount.
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 4; k++) begin
        run_word($sformatf("rt_%0d_%0d", v, k), rotr(WIDTH'(v), k), k, WIDTH'(v));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unshifter.md
# unshifter

Sequential left-rotator that undoes the right rotation applied by the existing `shifter` block. It accepts a rotated word and its rotation amount over a valid/ready handshake, rotates left one position per cycle until the amount is consumed, then presents the restored word on a registered output with its own valid/ready handshake. It sits on the receive side of any path that carries `shifter` output plus its `shift` value, and guarantees unshifter(rotr(x,k),k) = x.

## Interface
- WIDTH, 4: data width in bits; power of two, ≥ 2.
- SHW, $clog2(WIDTH): width of the rotation amount.
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  `in`/`shift` are valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in  input  WIDTH  right-rotated data word.
- shift  input  SHW  right-rotation amount previously applied to `in`.
- out_valid  output  1  `q` holds a restored word.
- out_ready  input  1  consumer accepts `q`.
- q  output  WIDTH  restored (left-rotated) word; registered.

## Operation
- The FSM has three states: IDLE, ROT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: data register ← `in`, counter ← `shift`, go to ROT.
- ROT:
  - If counter ≠ 0: data ← {data[WIDTH-2:0], data[WIDTH-1]}, counter ← counter−1, stay in ROT.
  - If counter = 0: q ← data, go to DONE.
- DONE:
  - out_valid=1; q is stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored, and in_ready=0.
- `in` and `shift` are sampled only at the acceptance edge. Later changes on those inputs have no effect.
- Rotation is modulo WIDTH by construction, because shift < WIDTH. No wrap handling is needed beyond the register feedback.
- `q` keeps its last value in IDLE and ROT. It is updated only on the ROT→DONE transition.
- There is no overlap: a new word is accepted only after the previous result has been consumed.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, q=0, out_valid=0, in_ready=1, counter=0, data=0.
- Reset mid-operation, in ROT or DONE: the operation is aborted and the result is lost. The next cycle is IDLE with the reset values above.
- Handshake in cycle n with shift=k:
  - Cycles n+1 … n+k perform the k rotations.
  - Cycle n+k+1 is ROT with counter=0.
  - out_valid rises in cycle n+k+2.
- Output handshake in cycle m (out_valid && out_ready): in_ready=1 in cycle m+1. The earliest next acceptance is cycle m+1.
- Throughput: one word per k+3 cycles when out_ready is held high.
- out_ready held low: out_valid and q hold indefinitely.

## Configuration
- Macro: UNSHIFTER_ZERO_BYPASS_EN.
- Defined: acceptance with shift=0 goes directly IDLE→DONE and loads q ← in. out_valid rises in cycle n+1.
- Undefined: shift=0 takes the normal path through ROT. out_valid rises in cycle n+2.
- Nonzero shifts are identical in both builds.

## Structure
- Package `unshifter_pkg`:
  - typedef enum logic [1:0] {IDLE, ROT, DONE} unshifter_state_t.
  - Default WIDTH constant, shared with `shifter` benches.
- Sub-module `unshifter_rotl1`: combinational one-position left rotate, parameterized by WIDTH, instantiated on the data-register feedback path.
- Elaboration check: WIDTH is a power of two and ≥ 2.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → q=0000, out_valid=0, in_ready=1 in the cycle after release.
- Accept in=1000, shift=1 in cycle n, out_ready=1 → q=0001 with out_valid=1 in cycle n+3 only; in_ready=1 in cycle n+4.
- Accept in=0001, shift=3 → q=1000 in cycle n+5. Accept in=0110, shift=2 → q=1001.
- Accept in=1010, shift=0 → q=1010 in cycle n+2 (macro undefined) or in cycle n+1 (UNSHIFTER_ZERO_BYPASS_EN defined).
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and a different `in` → q and out_valid held, in_ready=0, no new word captured.
- Abort and round-trip:
  - Drive rst_n=0 during ROT of in=0100, shift=3 → next cycle IDLE, q=0000, out_valid=0.
  - Then sweep all 16 values × 4 shifts through `shifter` into this block → q equals the original value for every case.
